// File: rtl/fsk_demod_rx_pkg.sv
// Shared tone plan, FSM encoding and per-edge event payload for the FSK receiver.
// FSK_RX_ERRCNT_EN adds the error-counter width used by the optional ERR_CNT port.
package fsk_demod_rx_pkg;

  localparam int unsigned BIT_CYCLES = 16;
  localparam int unsigned P1_MIN     = 3;
  localparam int unsigned P1_MAX     = 5;
  localparam int unsigned P0_MIN     = 7;
  localparam int unsigned P0_MAX     = 9;
  localparam int unsigned ACQ_EDGES  = 4;
  localparam int unsigned TIMEOUT    = 32;
  localparam int unsigned CNT_W      = 6;
`ifdef FSK_RX_ERRCNT_EN
  localparam int unsigned ERR_W      = 8;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } rx_state_e;

  // One-cycle classification result for a measured tone period
  typedef struct packed {
    logic vld;
    logic bit_val;
    logic inv;
  } period_evt_t;

  function automatic logic in_window(input logic [CNT_W-1:0] p,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (32'(p) >= lo) && (32'(p) <= hi);
  endfunction

endpackage

// File: rtl/fsk_demod_rx_if.sv
// Receiver-side signal bundle: FSK waveform in, recovered bit stream and carrier flag out.
// FSK_RX_ERRCNT_EN adds the ERR_CNT signal.
interface fsk_demod_rx_if;
  import fsk_demod_rx_pkg::*;

  logic             FSK_IN;
  logic             RX_DATA;
  logic             RX_VALID;
  logic             CARRIER_DET;
`ifdef FSK_RX_ERRCNT_EN
  logic [ERR_W-1:0] ERR_CNT;
`endif

  modport master (
    input  FSK_IN,
    output RX_DATA,
    output RX_VALID,
`ifdef FSK_RX_ERRCNT_EN
    output ERR_CNT,
`endif
    output CARRIER_DET
  );

  modport slave (
    output FSK_IN,
    input  RX_DATA,
    input  RX_VALID,
`ifdef FSK_RX_ERRCNT_EN
    input  ERR_CNT,
`endif
    input  CARRIER_DET
  );

endinterface

// File: rtl/fsk_demod_rx_period_meter.sv
// Synchronises FSK_IN, measures rising-edge to rising-edge period and classifies it
// as tone '1', tone '0' or invalid; flags a saturated (timed-out) period counter.
module fsk_demod_rx_period_meter
  import fsk_demod_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fsk_in,
  output period_evt_t evt,
  output logic        timeout_c
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q,  prev_d;
  logic             seen_q,  seen_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  period_evt_t      evt_q,   evt_d;
  logic             rise_c;
  logic             sat_c;

  always_comb begin
    sync1_d = fsk_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    seen_d  = seen_q;
    evt_d   = '0;
    rise_c  = sync2_q & ~prev_q;
    sat_c   = (cnt_q == CNT_W'(TIMEOUT));
    cnt_d   = sat_c ? cnt_q : cnt_q + CNT_W'(1);
    // The edge wins over a simultaneous timeout; the first edge after a gap has no period
    if (rise_c) begin
      cnt_d  = CNT_W'(1);
      seen_d = 1'b1;
      if (seen_q) begin
        if (in_window(cnt_q, P1_MIN, P1_MAX)) begin
          evt_d.vld     = 1'b1;
          evt_d.bit_val = 1'b1;
        end else if (in_window(cnt_q, P0_MIN, P0_MAX)) begin
          evt_d.vld     = 1'b1;
        end else begin
          evt_d.inv     = 1'b1;
        end
      end
    end else if (sat_c) begin
      seen_d = 1'b0;
    end
  end

  assign timeout_c = sat_c & ~rise_c;
  assign evt       = evt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      seen_q  <= 1'b0;
      cnt_q   <= CNT_W'(1);
      evt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

endmodule

// File: rtl/fsk_demod_rx.sv
// FSK receiver top: carrier acquisition FSM, bit-timing counter and output strobes.
// Defining FSK_RX_ERRCNT_EN adds a saturating count of invalid periods seen in TRACK.
module fsk_demod_rx
  import fsk_demod_rx_pkg::*;
(
  input  logic           RX_CLK,
  input  logic           RESET_N,
  fsk_demod_rx_if.master rx
);

  period_evt_t      evt;
  logic             timeout_c;

  rx_state_e        state_q,   state_d;
  logic [CNT_W-1:0] acq_cnt_q, acq_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             dec_q,     dec_d;
  logic             data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             carrier_q, carrier_d;
`ifdef FSK_RX_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
`endif

  fsk_demod_rx_period_meter u_meter (
    .clk       (RX_CLK),
    .rst_n     (RESET_N),
    .fsk_in    (rx.FSK_IN),
    .evt       (evt),
    .timeout_c (timeout_c)
  );

  always_comb begin
    state_d   = state_q;
    acq_cnt_d = acq_cnt_q;
    bit_cnt_d = bit_cnt_q;
    dec_d     = dec_q;
    data_d    = data_q;
    valid_d   = 1'b0;
`ifdef FSK_RX_ERRCNT_EN
    err_cnt_d = err_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (evt.vld) begin
          state_d   = ACQ;
          acq_cnt_d = CNT_W'(1);
        end
      end
      ACQ: begin
        if (evt.inv) begin
          state_d   = IDLE;
          acq_cnt_d = '0;
        end else if (evt.vld) begin
          acq_cnt_d = acq_cnt_q + CNT_W'(1);
          if (acq_cnt_q + CNT_W'(1) >= CNT_W'(ACQ_EDGES)) begin
            state_d   = TRACK;
            bit_cnt_d = '0;
          end
        end
      end
      TRACK: begin
        bit_cnt_d = (bit_cnt_q == CNT_W'(BIT_CYCLES - 1)) ? '0 : bit_cnt_q + CNT_W'(1);
        // A tone change realigns bit timing and suppresses any coincident strobe
        if (evt.vld && (evt.bit_val != dec_q)) begin
          dec_d     = evt.bit_val;
          bit_cnt_d = '0;
        end else if (bit_cnt_q == CNT_W'(BIT_CYCLES / 2 - 1)) begin
          valid_d = 1'b1;
          data_d  = dec_q;
        end
`ifdef FSK_RX_ERRCNT_EN
        if (evt.inv && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Carrier loss overrides everything and drops any strobe of this cycle
    if (timeout_c) begin
      state_d   = IDLE;
      acq_cnt_d = '0;
      valid_d   = 1'b0;
      data_d    = data_q;
    end
    carrier_d = (state_d == TRACK);
  end

  always_ff @(posedge RX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      acq_cnt_q <= '0;
      bit_cnt_q <= '0;
      dec_q     <= 1'b0;
      data_q    <= 1'b0;
      valid_q   <= 1'b0;
      carrier_q <= 1'b0;
`ifdef FSK_RX_ERRCNT_EN
      err_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acq_cnt_q <= acq_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      dec_q     <= dec_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      carrier_q <= carrier_d;
`ifdef FSK_RX_ERRCNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign rx.RX_DATA     = data_q;
  assign rx.RX_VALID    = valid_q;
  assign rx.CARRIER_DET = carrier_q;
`ifdef FSK_RX_ERRCNT_EN
  assign rx.ERR_CNT     = err_cnt_q;
`endif

endmodule
